apix_transmitter: RTL and testbench



---
 rtl/apix_transmitter.sv | 94 +++++++++
 tb/tb_apix_transmitter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/apix_transmitter.sv
// Serialising pixel transmitter: one 24-bit pixel per frame, sent as
// sync header, data MSB first, then CRC-8 over the data bits.
module apix_transmitter #(
    parameter logic [3:0] SYNC_PATTERN = 4'b1010,
    parameter logic [7:0] CRC_POLY     = 8'h07,
    parameter logic [7:0] CRC_INIT     = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        apix_data,
    output logic        apix_clk
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] CRC  = 2'd3;

    logic [1:0]  state, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] shreg_q, shreg_d;
    logic [7:0]  crc, crc_d;
    logic        tx_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            crc     <= CRC_INIT;
        end else begin
            state   <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            crc     <= crc_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        crc_d   = crc;
        tx_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (pixel_valid) begin
                    shreg_d = pixel_data;
                    crc_d   = CRC_INIT;
                    cnt_d   = '0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                tx_bit = SYNC_PATTERN[2'd3 - cnt_q[1:0]];
                if (cnt_q == 5'd3) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DATA: begin
                tx_bit  = shreg_q[23];
                // CRC advances on the bit being sent this cycle
                crc_d   = {crc[6:0], 1'b0} ^ ((crc[7] ^ shreg_q[23]) ? CRC_POLY : 8'h00);
                shreg_d = {shreg_q[22:0], 1'b0};
                if (cnt_q == 5'd23) begin
                    cnt_d   = '0;
                    state_d = CRC;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            CRC: begin
                tx_bit = crc[3'd7 - cnt_q[2:0]];
                if (cnt_q == 5'd7) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst_n so the line drops the moment reset asserts
    assign apix_data = rst_n & tx_bit;
    assign apix_clk  = clk;

endmodule

// File: tb/tb_apix_transmitter.sv
// Directed bench for apix_transmitter: a behavioural frame model checks
// apix_data every cycle; directed frames are compared against constants.
module tb_apix_transmitter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        apix_data;
    logic        apix_clk;

    int errors = 0;
    int checks = 0;

    int          pos = 0;
    logic [35:0] frame = '0;
    logic [35:0] rx = '0;
    int          n_dut = 0;
    int          n0;
    logic [1:0]  st_prev = S_IDLE;

    apix_transmitter dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .apix_data(apix_data), .apix_clk(apix_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [23:0] d);
        logic [7:0] c = 8'h00;
        for (int b = 2; b >= 0; b--) begin
            c = c ^ d[b*8 +: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    always @(posedge clk) begin
        #1 chk("apix_clk_hi", {35'd0, apix_clk}, 36'd1);
    end
    always @(negedge clk) begin
        #1 chk("apix_clk_lo", {35'd0, apix_clk}, 36'd0);
    end

    // Count frame starts as seen inside the DUT
    always @(negedge clk) begin
        if (st_prev == S_IDLE && dut.state == S_SYNC) n_dut++;
        st_prev = dut.state;
    end

    // Advance one clock, step the frame model, and compare the line bit
    task automatic tick();
        logic        v_pre = pixel_valid;
        logic [23:0] d_pre = pixel_data;
        logic        r_pre = rst_n;
        logic        exp;
        @(posedge clk);
        #1;
        if (!r_pre) pos = 0;
        else if (pos == 0) begin
            if (v_pre) begin
                frame = {4'b1010, d_pre, crc8(d_pre)};
                pos = 1;
            end
        end else if (pos == 36) pos = 0;
        else pos++;
        exp = (r_pre && pos != 0) ? frame[36-pos] : 1'b0;
        chk("apix_data", {35'd0, apix_data}, {35'd0, exp});
        if (!r_pre) chk("reset_state", {34'd0, dut.state}, {34'd0, S_IDLE});
        if (pos >= 29) chk("crc_hold", {28'd0, dut.crc}, {28'd0, frame[7:0]});
        rx = {rx[34:0], apix_data};
    endtask

    initial begin
        rst_n = 1'b0;
        pixel_valid = 1'b0;
        pixel_data = '0;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // single pixel held 10 cycles -> exactly one frame
        n0 = n_dut;
        pixel_data = 24'hABCDEF;
        pixel_valid = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (i == 10) pixel_valid = 1'b0;
            tick();
        end
        chk("frame_abcdef", rx, {4'b1010, 24'hABCDEF, 8'h23});
        repeat (5) tick();
        chk("one_frame", 36'(n_dut - n0), 36'd1);

        // all-zero pixel
        pixel_data = 24'h000000;
        pixel_valid = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (i == 1) pixel_valid = 1'b0;
            tick();
            if (i >= 28) chk("crc_zero", {28'd0, dut.crc}, 36'd0);
        end
        chk("frame_zero", rx, {4'b1010, 24'h0, 8'h00});
        repeat (3) tick();

        // random pixels, 8 cycles each, valid continuous
        n0 = n_dut;
        pixel_valid = 1'b1;
        for (int c = 0; c < 1080 * 8; c++) begin
            if (c % 8 == 0) pixel_data = 24'($urandom);
            tick();
        end
        pixel_valid = 1'b0;
        chk("random_frames", 36'(n_dut - n0), 36'd234);

        // idle line after traffic
        repeat (50) tick();
        chk("idle_line", {35'd0, apix_data}, 36'd0);

        // reset in mid-frame, then a fresh frame
        pixel_data = 24'h55AA55;
        pixel_valid = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1 chk("reset_immediate", {35'd0, apix_data}, 36'd0);
        repeat (5) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (i == 1) pixel_valid = 1'b0;
            tick();
        end
        chk("frame_after_reset", rx, {4'b1010, 24'h55AA55, 8'hD2});
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
